// File: rtl/axil_core_cmd_slave.sv
// axil_core_cmd_slave: AXI4-Lite register slave that feeds the six-core array.
// Holds four operand registers, issues one command at a time to a core over a
// valid/ready handshake, captures the returned result and reports status.
// Optional macro AXIL_CMD_IRQ_EN: when defined, irq = registered (ie & done);
// when undefined, irq is tied low (ie still reads back through CMD).
module axil_core_cmd_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_CORES          = 6
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output logic [2:0]                      cmd_core,
   output logic [127:0]                    cmd_data,
   input  logic                            res_valid,
   input  logic [31:0]                     res_data,
   output logic                            irq
);

   localparam logic [2:0] IDX_CMD    = 3'd4;
   localparam logic [2:0] IDX_STATUS = 3'd5;
   localparam logic [2:0] IDX_RESULT = 3'd6;
   localparam logic [3:0] NCORES     = 4'(NUM_CORES);

   // write-channel holding state
   logic        aw_full, w_full;
   logic [2:0]  aw_idx;
   logic [31:0] w_data;
   logic [3:0]  w_strb;

   logic [31:0] regs [4];
   logic [31:0] result;
   logic        done, ie;

   logic        aw_hs, w_hs, ar_hs, wr_fire;
   logic [2:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, rd_mux;
   logic [3:0]  wr_strb;
   logic        cmd_go, cmd_ok;

   // byte-offset address bits carry no information for word registers
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // READYs are gated by reset so the channels look idle while it is held
   assign S_AXI_AWREADY = !ARESET && !aw_full && !S_AXI_BVALID;
   assign S_AXI_WREADY  = !ARESET && !w_full && !S_AXI_BVALID;
   assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;
   assign S_AXI_RRESP   = 2'b00;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // a write fires on the edge where both halves are available, latched or live
   assign wr_fire = (aw_full || aw_hs) && (w_full || w_hs);
   assign wr_idx  = aw_full ? aw_idx : S_AXI_AWADDR[4:2];
   assign wr_data = w_full ? w_data : S_AXI_WDATA;
   assign wr_strb = w_full ? w_strb : S_AXI_WSTRB;
   assign rd_idx  = S_AXI_ARADDR[4:2];

   assign cmd_go = wr_fire && (wr_idx == IDX_CMD) && wr_data[0];
   assign cmd_ok = cmd_go && !cmd_valid && ({1'b0, wr_data[3:1]} < NCORES);

   // read data selection for the register map
   always_comb begin
      rd_mux = 32'h0;
      case (rd_idx)
         3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs[rd_idx[1:0]];
         IDX_CMD:                rd_mux = {27'b0, ie, 4'b0};
         IDX_STATUS:             rd_mux = {30'b0, done, cmd_valid};
         IDX_RESULT:             rd_mux = result;
         default:                rd_mux = 32'h0;
      endcase
   end

   // write address/data capture and write response
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_idx       <= 3'd0;
         w_data       <= 32'h0;
         w_strb       <= 4'h0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (wr_fire) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= (cmd_go && !cmd_ok) ? 2'b10 : 2'b00;
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   // byte-strobed operand registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
      end else if (wr_fire && !wr_idx[2]) begin
         for (int b = 0; b < 4; b++)
            if (wr_strb[b]) regs[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   // command issue: one outstanding command, operands snapshotted at issue
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ie        <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_core  <= 3'd0;
         cmd_data  <= 128'h0;
      end else begin
         if (wr_fire && wr_idx == IDX_CMD) ie <= wr_data[4];
         if (cmd_ok) begin
            cmd_valid <= 1'b1;
            cmd_core  <= wr_data[3:1];
            cmd_data  <= {regs[3], regs[2], regs[1], regs[0]};
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
      end
   end

   // result capture; an arriving result wins over any clear of done
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         result <= 32'h0;
         done   <= 1'b0;
      end else if (res_valid) begin
         result <= res_data;
         done   <= 1'b1;
      end else if (cmd_ok || (ar_hs && rd_idx == IDX_RESULT)) begin
         done <= 1'b0;
      end
   end

   // read channel: one-cycle registered response, held until RREADY
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= 32'h0;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

`ifdef AXIL_CMD_IRQ_EN
   // completion interrupt, one cycle behind done
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) irq <= 1'b0;
      else        irq <= ie & done;
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_axil_core_cmd_slave.sv
// Self-checking bench for axil_core_cmd_slave: directed scenarios plus a
// randomized mix checked against a register-map level reference model.
module tb_axil_core_cmd_slave;

   logic         ACLK = 1'b0;
   logic         ARESET = 1'b1;
   logic [4:0]   S_AXI_AWADDR = '0;
   logic         S_AXI_AWVALID = 1'b0;
   logic         S_AXI_AWREADY;
   logic [31:0]  S_AXI_WDATA = '0;
   logic [3:0]   S_AXI_WSTRB = '0;
   logic         S_AXI_WVALID = 1'b0;
   logic         S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID;
   logic         S_AXI_BREADY = 1'b0;
   logic [4:0]   S_AXI_ARADDR = '0;
   logic         S_AXI_ARVALID = 1'b0;
   logic         S_AXI_ARREADY;
   logic [31:0]  S_AXI_RDATA;
   logic [1:0]   S_AXI_RRESP;
   logic         S_AXI_RVALID;
   logic         S_AXI_RREADY = 1'b0;
   logic         cmd_valid;
   logic         cmd_ready = 1'b0;
   logic [2:0]   cmd_core;
   logic [127:0] cmd_data;
   logic         res_valid = 1'b0;
   logic [31:0]  res_data = '0;
   logic         irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0]  m_regs [4];
   logic [31:0]  m_result;
   logic         m_done, m_ie, m_pend;
   logic [2:0]   m_core;
   logic [127:0] m_cdata;

   axil_core_cmd_slave dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_core(cmd_core), .cmd_data(cmd_data),
      .res_valid(res_valid), .res_data(res_data), .irq(irq)
   );

   always #5 ACLK = ~ACLK;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
      m_result = 32'h0; m_done = 1'b0; m_ie = 1'b0; m_pend = 1'b0;
      m_core = 3'd0; m_cdata = 128'h0;
   endfunction

   // applies a completed write to the model and returns the expected BRESP
   function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
      int idx = int'(a[4:2]);
      logic [1:0] resp = 2'b00;
      if (idx < 4) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
      end else if (idx == 4) begin
         m_ie = d[4];
         if (d[0]) begin
            if (m_pend || int'(d[3:1]) >= 6) resp = 2'b10;
            else begin
               m_pend = 1'b1; m_core = d[3:1]; m_done = 1'b0;
               m_cdata = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
            end
         end
      end
      return resp;
   endfunction

   // returns the expected read data and applies the read's side effects
   function automatic logic [31:0] model_read(input logic [4:0] a, input bit res_same,
                                              input logic [31:0] v);
      int idx = int'(a[4:2]);
      logic [31:0] r = 32'h0;
      if (idx < 4) r = m_regs[idx];
      else if (idx == 4) r = m_ie ? 32'h10 : 32'h0;
      else if (idx == 5) r = {30'b0, m_done, m_pend};
      else if (idx == 6) r = m_result;
      if (res_same) begin m_result = v; m_done = 1'b1; end
      else if (idx == 6) m_done = 1'b0;
      return r;
   endfunction

   // one AXI write; AW and W offered after independent delays (in cycles)
   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold,
                            output logic [1:0] resp);
      bit aw_done = 0, w_done = 0;
      logic aw_hs, w_hs;
      int cyc = 0;
      resp = 2'bxx;
      while (!(aw_done && w_done) && cyc < 40) begin
         S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
         S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
         S_AXI_WVALID  = !w_done && cyc >= w_dly;
         @(negedge ACLK);
         checks++;
         if (S_AXI_BVALID !== 1'b0) begin
            errors++; $display("FAIL bvalid_early: got %b required 0", S_AXI_BVALID);
         end
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK); #1;
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
         cyc++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      checks++;
      if (!(aw_done && w_done)) begin
         errors++; $display("FAIL write_timeout: aw %0d w %0d required both", aw_done, w_done);
         return;
      end
      checks++;
      if (S_AXI_BVALID !== 1'b1) begin
         errors++; $display("FAIL bvalid_rise: got %b required 1", S_AXI_BVALID);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge ACLK);
         checks++;
         if (S_AXI_BVALID !== 1'b1) begin
            errors++; $display("FAIL bvalid_hold: got %b required 1", S_AXI_BVALID);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      resp = S_AXI_BRESP;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b0) begin
         errors++; $display("FAIL bvalid_drop: got %b required 0", S_AXI_BVALID);
      end
   endtask

   // one AXI read; optionally pulses res_valid in the AR handshake cycle
   task automatic axi_read(input logic [4:0] a, input int hold, input bit res_same,
                           input logic [31:0] v, output logic [31:0] d, output logic [1:0] r);
      bit ok = 0;
      d = 'x; r = 'x;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_AXI_ARREADY;
         if (ok && res_same) begin res_valid = 1'b1; res_data = v; end
         @(posedge ACLK); #1;
      end
      S_AXI_ARVALID = 1'b0; res_valid = 1'b0;
      checks++;
      if (!ok || S_AXI_RVALID !== 1'b1) begin
         errors++; $display("FAIL read_handshake: arready %0d rvalid %b required 1/1", ok, S_AXI_RVALID);
         return;
      end
      d = S_AXI_RDATA; r = S_AXI_RRESP;
      for (int h = 0; h < hold; h++) begin
         @(negedge ACLK);
         checks++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== d) begin
            errors++; $display("FAIL rdata_hold: got %b/%h required 1/%h", S_AXI_RVALID, S_AXI_RDATA, d);
         end
         @(posedge ACLK); #1;
      end
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b0) begin
         errors++; $display("FAIL rvalid_drop: got %b required 0", S_AXI_RVALID);
      end
   endtask

   task automatic res_pulse(input logic [31:0] v);
      res_valid = 1'b1; res_data = v;
      @(posedge ACLK); #1;
      res_valid = 1'b0;
      m_result = v; m_done = 1'b1;
   endtask

   task automatic cmd_accept();
      cmd_ready = 1'b1;
      @(negedge ACLK);
      checks++;
      if (cmd_valid !== m_pend || (m_pend && (cmd_core !== m_core || cmd_data !== m_cdata))) begin
         errors++;
         $display("FAIL cmd_out: got %b/%0d/%h required %b/%0d/%h", cmd_valid, cmd_core, cmd_data,
                  m_pend, m_core, m_cdata);
      end
      @(posedge ACLK); #1;
      cmd_ready = 1'b0; m_pend = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++; $display("FAIL cmd_drop: got %b required 0", cmd_valid);
      end
   endtask

   task automatic test_reset();
      model_reset();
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY, S_AXI_RVALID,
           S_AXI_RDATA, S_AXI_RRESP, cmd_valid, cmd_core, cmd_data, irq} !== '0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero during reset");
      end
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
         errors++;
         $display("FAIL idle_after_reset: got %b required 11100",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
      end
   endtask

   task automatic test_regs();
      logic [1:0] resp, r; logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(4*i), 32'(i+1), 4'hF, 0, 0, i, resp);
         void'(model_write(5'(4*i), 32'(i+1), 4'hF));
         checks++;
         if (resp !== 2'b00) begin errors++; $display("FAIL reg_wr_resp: got %b required 00", resp); end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(4*i), i, 0, 0, d, r);
         void'(model_read(5'(4*i), 0, 0));
         checks++;
         if (d !== 32'(i+1) || r !== 2'b00) begin
            errors++; $display("FAIL reg_rd%0d: got %h/%b required %h/00", i, d, r, i+1);
         end
      end
   endtask

   task automatic test_strobe_order();
      logic [1:0] resp, r; logic [31:0] d;
      axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 3, 0, 1, resp);
      void'(model_write(5'h04, 32'hAABBCCDD, 4'b0010));
      axi_read(5'h04, 0, 0, 0, d, r);
      void'(model_read(5'h04, 0, 0));
      checks++;
      if (d !== 32'h0000CC02 || resp !== 2'b00) begin
         errors++; $display("FAIL strobe_w_first: got %h/%b required 0000cc02/00", d, resp);
      end
   endtask

   task automatic test_cmd();
      logic [1:0] resp;
      axi_write(5'h10, 32'h5, 4'hF, 0, 0, 0, resp);
      void'(model_write(5'h10, 32'h5, 4'hF));
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL cmd_go_resp: got %b required 00", resp); end
      for (int c = 0; c < 4; c++) begin
         @(negedge ACLK);
         checks++;
         if (cmd_valid !== 1'b1 || cmd_core !== 3'd2) begin
            errors++; $display("FAIL cmd_hold c%0d: got %b/%0d required 1/2", c, cmd_valid, cmd_core);
         end
         @(posedge ACLK); #1;
      end
      checks++;
      if (cmd_data !== 128'h00000004_00000003_0000CC02_00000001) begin
         errors++; $display("FAIL cmd_snapshot: got %h", cmd_data);
      end
      axi_write(5'h10, 32'h5, 4'hF, 1, 0, 0, resp);
      void'(model_write(5'h10, 32'h5, 4'hF));
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL cmd_busy_go: got %b required 10", resp); end
      cmd_accept();
   endtask

   task automatic test_bad_core();
      logic [1:0] resp;
      axi_write(5'h10, 32'hF, 4'hF, 0, 2, 0, resp);
      void'(model_write(5'h10, 32'hF, 4'hF));
      checks++;
      if (resp !== 2'b10 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL bad_core: got %b/%b required 10/0", resp, cmd_valid);
      end
   endtask

   task automatic test_result();
      logic [1:0] r; logic [31:0] d;
      res_pulse(32'hDEADBEEF);
      axi_read(5'h14, 0, 0, 0, d, r); void'(model_read(5'h14, 0, 0));
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL status_done: got %h required 2", d); end
      axi_read(5'h18, 0, 0, 0, d, r); void'(model_read(5'h18, 0, 0));
      checks++;
      if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL result_rd: got %h required deadbeef", d); end
      axi_read(5'h14, 0, 0, 0, d, r); void'(model_read(5'h14, 0, 0));
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL status_clear: got %h required 0", d); end
   endtask

   task automatic test_same_cycle();
      logic [1:0] r; logic [31:0] d;
      axi_read(5'h18, 1, 1, 32'h12345678, d, r); void'(model_read(5'h18, 1, 32'h12345678));
      checks++;
      if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL same_cycle_old: got %h required deadbeef", d); end
      axi_read(5'h14, 0, 0, 0, d, r); void'(model_read(5'h14, 0, 0));
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL same_cycle_done: got %h required 2", d); end
      axi_read(5'h18, 0, 0, 0, d, r); void'(model_read(5'h18, 0, 0));
      checks++;
      if (d !== 32'h12345678) begin errors++; $display("FAIL same_cycle_new: got %h required 12345678", d); end
   endtask

   task automatic test_irq();
      logic [1:0] resp, r; logic [31:0] d;
      axi_write(5'h10, 32'h10, 4'hF, 0, 0, 0, resp);
      void'(model_write(5'h10, 32'h10, 4'hF));
      axi_read(5'h10, 0, 0, 0, d, r); void'(model_read(5'h10, 0, 0));
      checks++;
      if (d !== 32'h10) begin errors++; $display("FAIL ie_readback: got %h required 10", d); end
      res_pulse(32'hCAFE0001);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", irq); end
      @(posedge ACLK); #1;
`ifdef AXIL_CMD_IRQ_EN
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
`else
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b required 0", irq); end
`endif
      axi_read(5'h18, 0, 0, 0, d, r); void'(model_read(5'h18, 0, 0));
      checks++;
      if (irq !== 1'b0 || d !== 32'hCAFE0001) begin
         errors++; $display("FAIL irq_clear: got %b/%h required 0/cafe0001", irq, d);
      end
      axi_write(5'h10, 32'h0, 4'hF, 0, 0, 0, resp);
      void'(model_write(5'h10, 32'h0, 4'hF));
   endtask

   task automatic test_random();
      logic [1:0] resp, r, er; logic [31:0] d, ed, v; logic [4:0] a; logic [3:0] s; bit same;
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 5))
            0, 1: begin
               a = 5'($urandom_range(0, 7) * 4);
               d = $urandom; s = 4'($urandom);
               if (a == 5'h10 && $urandom_range(0, 1) == 1) d[0] = 1'b0;
               axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
               er = model_write(a, d, s);
               checks++;
               if (resp !== er) begin
                  errors++; $display("FAIL rand_wr a=%h d=%h: got %b required %b", a, d, resp, er);
               end
            end
            2, 3: begin
               a = 5'($urandom_range(0, 7) * 4);
               same = ($urandom_range(0, 3) == 0); v = $urandom;
               axi_read(a, $urandom_range(0, 2), same, v, d, r);
               ed = model_read(a, same, v);
               checks++;
               if (d !== ed || r !== 2'b00) begin
                  errors++; $display("FAIL rand_rd a=%h: got %h/%b required %h/00", a, d, r, ed);
               end
            end
            4: cmd_accept();
            default: res_pulse($urandom);
         endcase
         checks++;
         if (cmd_valid !== m_pend) begin
            errors++; $display("FAIL rand_cmd_valid: got %b required %b", cmd_valid, m_pend);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp, r; logic [31:0] d;
      S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
      @(negedge ACLK); @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
      @(negedge ACLK); @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      ARESET = 1'b1;
      #1;
      checks++;
      if ({S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY, cmd_valid} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_async: got %b required 0000",
                            {S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY, cmd_valid});
      end
      @(posedge ACLK); @(posedge ACLK); #1;
      ARESET = 1'b0;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge ACLK);
         checks++;
         if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
            errors++; $display("FAIL aborted_resp: got %b/%b required 0/0", S_AXI_BVALID, S_AXI_RVALID);
         end
      end
      @(posedge ACLK); #1;
      axi_write(5'h04, 32'h77, 4'hF, 2, 0, 0, resp);
      void'(model_write(5'h04, 32'h77, 4'hF));
      axi_read(5'h00, 0, 0, 0, d, r); void'(model_read(5'h00, 0, 0));
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reg0_after_reset: got %h required 0", d); end
      axi_read(5'h04, 0, 0, 0, d, r); void'(model_read(5'h04, 0, 0));
      checks++;
      if (d !== 32'h77) begin errors++; $display("FAIL reg1_after_reset: got %h required 77", d); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_strobe_order();
      test_cmd();
      test_bad_core();
      test_result();
      test_same_cycle();
      test_irq();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
